phase_synth_bank: RTL
=====================

# phase_synth_bank

Parametrised multi-channel phase synthesizer: CH_NUM independent NCO phase accumulators with per-channel init, a common interrupt/epoch timebase, signed full-cycle counting and interrupt-time snapshots. Next generation of the imitator correlator's single-channel synthesizer. Adds configurable widths, per-channel initial phase offset, a snapshot-valid strobe and optional linear frequency ramp (chirp). Sits between the imitator's register file (rates, offsets, doinit) and the per-channel signal generators, which consume phase_addr.

## Interface
- CH_NUM, 4: number of channels.
- PHASE_W, 32: accumulator, rate and chirp width.
- CYCLES_W, 32: signed full-cycle counter width.
- ADDR_W, 5: phase address width (accumulator MSBs); ADDR_W <= PHASE_W.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- phase_rate  in  CH_NUM*PHASE_W  per-channel rate, two's complement; channel c at [c*PHASE_W +: PHASE_W].
- phase_offset  in  CH_NUM*PHASE_W  per-channel initial phase, loaded on init.
- chirp_rate  in  CH_NUM*PHASE_W  per-channel rate increment per clk. Present only with PHASE_SYNTH_CHIRP_EN.
- doinit  in  CH_NUM  per-channel init request, qualified by intr_pulse.
- intr_pulse  in  1  common interrupt strobe; snapshot and init qualifier.
- epoch_pulse  in  1  common epoch strobe; rate reload.
- phase_rate_int  out  CH_NUM*PHASE_W  live working rate per channel.
- phase_int  out  CH_NUM*PHASE_W  accumulator snapshot.
- phase_cycles_int  out  CH_NUM*CYCLES_W  cycle-counter snapshot, signed.
- phase_addr  out  CH_NUM*ADDR_W  live accumulator[PHASE_W-1 -: ADDR_W].
- int_valid  out  1  one-clk strobe; snapshots updated.

## Operation
- Per channel c: load = doinit[c] & intr_pulse.
- Rate register: on load | epoch_pulse, rate <= phase_rate[c]. Otherwise it holds. With chirp, rate <= rate + chirp instead, mod 2^PHASE_W.
- Chirp register: on load | epoch_pulse, chirp <= chirp_rate[c]. Otherwise it holds.
- Accumulator:
  - On load, acc <= phase_offset[c].
  - Otherwise acc <= acc + rate, mod 2^PHASE_W, unsigned add with carry-out.
- Cycle counter, signed CYCLES_W, uses the sign of the working rate register (not the input port):
  - On load, cycles <= 0.
  - Else if rate >= 0 and carry = 1: +1.
  - Else if rate < 0 and carry = 0: −1.
  - Else hold.
  - rate = 0 never changes cycles. Counter wraps mod 2^CYCLES_W.
- Snapshot: on intr_pulse, phase_int <= acc and phase_cycles_int <= cycles. Both capture values present before that edge's update, for all channels.
- int_valid <= intr_pulse, registered.
- Simultaneous load and intr_pulse on a channel: snapshot takes pre-load values; the channel restarts at the same edge.
- Simultaneous load and epoch_pulse: identical rate load; load still resets acc/cycles.
- epoch_pulse alone: rate/chirp reload only; acc and cycles continue.
- Channels are fully independent except for the shared intr_pulse and epoch_pulse.

## Timing
- All state updates on posedge clk. Reset: every output and internal register is 0, asserted asynchronously; deassertion is synchronised upstream.
- Reset mid-operation clears everything immediately. The first update occurs on the first edge after release.
- Latency:
  - load/epoch → phase_rate_int: 1 clk.
  - load → acc = offset: 1 clk. The first increment by the new rate is at the next edge.
  - phase_addr is registered and reflects acc with no extra delay.
  - intr_pulse → phase_int/phase_cycles_int/int_valid: 1 clk, all valid in the same cycle.
- Back-to-back intr_pulse is allowed: every cycle snapshots, and int_valid stays high.
- No handshake or backpressure.

## Configuration
- PHASE_SYNTH_CHIRP_EN defined: chirp_rate port and chirp registers exist. The rate ramps by chirp each clk, except on load/epoch edges.
- Undefined: chirp_rate port and registers are absent. Rate is constant between load/epoch, with behaviour identical to a plain NCO bank.

## Structure
- Shared package phase_synth_pkg holds default widths (PHASE_W, CYCLES_W, ADDR_W, CH_NUM) and the slice helper for channel c of a flattened bus.
- Sub-module phase_synth_channel implements one channel (rate, chirp, acc, cycles, snapshots). The top instantiates CH_NUM of them in a generate loop and registers int_valid.

## Test plan
- Reset, random inputs held: all outputs 0, int_valid 0; after release with rate 0, outputs stay 0.
- Positive wrap, ch0:
  - Setup: rate 0x0800_0000, offset 0, load at E0, intr at E64.
  - phase_addr steps +1/clk and wraps 31→0 at E32.
  - phase_int = 0xF800_0000, phase_cycles_int = 1, int_valid high for 1 clk.
- Negative rate, ch0:
  - Setup: rate 0xF800_0000, offset 0, load at E0, intr at E40.
  - cycles is −1 at E1 and −2 at E33.
  - phase_cycles_int = 0xFFFF_FFFE.
- Epoch and load isolation:
  - epoch_pulse at E10 with rate 0x1000_0000 changes the increment from E11 onward. acc and cycles are not reset.
  - doinit = 4'b0001 with intr: ch0 snapshots pre-load values and restarts at offset 0x1234_0000. ch1–3 continue uninterrupted.
- Chirp (macro defined):
  - Setup: rate 0, chirp 1, load at E0.
  - Accumulator at En = n(n−1)/2, so acc = 45 at E10, and phase_rate_int = 10.
  - Macro undefined: acc stays 0.
- Reset asserted mid-run at E20: all outputs 0 without a clock edge. Restart from 0 after release.

Source files
------------

// File: rtl/phase_synth_pkg.sv
// phase_synth_pkg: shared defaults and helpers for the phase synthesizer bank.
//   DEFAULT_CH_NUM   : default channel count
//   DEFAULT_PHASE_W  : default accumulator / rate / chirp width
//   DEFAULT_CYCLES_W : default signed full-cycle counter width
//   DEFAULT_ADDR_W   : default phase address width (accumulator MSBs)
//   slice_lo()       : low bit index of channel c inside a flattened bus
package phase_synth_pkg;

  localparam int DEFAULT_CH_NUM   = 4;
  localparam int DEFAULT_PHASE_W  = 32;
  localparam int DEFAULT_CYCLES_W = 32;
  localparam int DEFAULT_ADDR_W   = 5;

  // Channel c of a bus built from equal w-bit fields starts at bit c*w.
  function automatic int slice_lo(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/phase_synth_channel.sv
// phase_synth_channel: one NCO channel of the phase synthesizer bank.
// Optional feature macro: PHASE_SYNTH_CHIRP_EN (adds chirp_in and a chirp
// register that ramps the working rate every clock).
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   rate_in       : rate reloaded on load/epoch (two's complement)
//   offset_in     : initial accumulator value applied on load
//   chirp_in      : rate increment per clock (only with PHASE_SYNTH_CHIRP_EN)
//   load          : channel restart (doinit qualified by intr_pulse)
//   epoch_pulse   : rate (and chirp) reload, accumulator keeps running
//   intr_pulse    : snapshot strobe
//   rate          : live working rate
//   phase_snap    : accumulator snapshot
//   cycles_snap   : signed full-cycle counter snapshot
//   addr          : live accumulator MSBs
module phase_synth_channel
  import phase_synth_pkg::*;
#(
  parameter int PHASE_W  = DEFAULT_PHASE_W,
  parameter int CYCLES_W = DEFAULT_CYCLES_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PHASE_W-1:0]  rate_in,
  input  logic [PHASE_W-1:0]  offset_in,
`ifdef PHASE_SYNTH_CHIRP_EN
  input  logic [PHASE_W-1:0]  chirp_in,
`endif
  input  logic                load,
  input  logic                epoch_pulse,
  input  logic                intr_pulse,
  output logic [PHASE_W-1:0]  rate,
  output logic [PHASE_W-1:0]  phase_snap,
  output logic [CYCLES_W-1:0] cycles_snap,
  output logic [ADDR_W-1:0]   addr
);

  localparam logic [CYCLES_W-1:0] CYCLES_ONE = CYCLES_W'(1);

  logic [PHASE_W-1:0]  rate_reg;
  logic [PHASE_W-1:0]  acc_reg;
  logic [CYCLES_W-1:0] cycles_reg;
  logic [PHASE_W-1:0]  phase_snap_reg;
  logic [CYCLES_W-1:0] cycles_snap_reg;
`ifdef PHASE_SYNTH_CHIRP_EN
  logic [PHASE_W-1:0]  chirp_reg;
`endif

  logic [PHASE_W-1:0]  acc_next;
  logic                carry;
  logic [CYCLES_W-1:0] cycles_next;

  // Unsigned add; the carry-out marks a full-cycle crossing.
  assign {carry, acc_next} = {1'b0, acc_reg} + {1'b0, rate_reg};

  // A positive rate completes a cycle when the add carries; a negative rate
  // (a large unsigned add) completes one backwards when it does not carry.
  // A zero rate never carries, so it leaves the counter alone.
  always_comb begin
    cycles_next = cycles_reg;
    if (!rate_reg[PHASE_W-1] && carry) begin
      cycles_next = cycles_reg + CYCLES_ONE;
    end else if (rate_reg[PHASE_W-1] && !carry) begin
      cycles_next = cycles_reg - CYCLES_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_reg        <= '0;
      acc_reg         <= '0;
      cycles_reg      <= '0;
      phase_snap_reg  <= '0;
      cycles_snap_reg <= '0;
`ifdef PHASE_SYNTH_CHIRP_EN
      chirp_reg       <= '0;
`endif
    end else begin
      if (load || epoch_pulse) begin
        rate_reg  <= rate_in;
`ifdef PHASE_SYNTH_CHIRP_EN
        chirp_reg <= chirp_in;
      end else begin
        rate_reg  <= rate_reg + chirp_reg;
`endif
      end

      if (load) begin
        acc_reg    <= offset_in;
        cycles_reg <= '0;
      end else begin
        acc_reg    <= acc_next;
        cycles_reg <= cycles_next;
      end

      // Snapshot sees the pre-update values, including on a load edge.
      if (intr_pulse) begin
        phase_snap_reg  <= acc_reg;
        cycles_snap_reg <= cycles_reg;
      end
    end
  end

  assign rate        = rate_reg;
  assign phase_snap  = phase_snap_reg;
  assign cycles_snap = cycles_snap_reg;
  assign addr        = acc_reg[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/phase_synth_bank.sv
// phase_synth_bank: CH_NUM independent NCO phase accumulators sharing an
// interrupt/epoch timebase, with interrupt-time snapshots.
// Optional feature macro: PHASE_SYNTH_CHIRP_EN (linear rate ramp per channel;
// adds the chirp_rate port).
// Ports (channel c occupies [c*W +: W] of each flattened bus):
//   clk, reset_n     : clock, asynchronous active-low reset
//   phase_rate       : per-channel rate, two's complement
//   phase_offset     : per-channel initial phase, loaded on init
//   chirp_rate       : per-channel rate increment per clk (chirp build only)
//   doinit           : per-channel init request, qualified by intr_pulse
//   intr_pulse       : common snapshot strobe / init qualifier
//   epoch_pulse      : common rate reload strobe
//   phase_rate_int   : live working rate per channel
//   phase_int        : accumulator snapshot per channel
//   phase_cycles_int : signed cycle-counter snapshot per channel
//   phase_addr       : live accumulator MSBs per channel
//   int_valid        : one-clk strobe, snapshots updated
module phase_synth_bank
  import phase_synth_pkg::*;
#(
  parameter int CH_NUM   = DEFAULT_CH_NUM,
  parameter int PHASE_W  = DEFAULT_PHASE_W,
  parameter int CYCLES_W = DEFAULT_CYCLES_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CH_NUM*PHASE_W-1:0]    phase_rate,
  input  logic [CH_NUM*PHASE_W-1:0]    phase_offset,
`ifdef PHASE_SYNTH_CHIRP_EN
  input  logic [CH_NUM*PHASE_W-1:0]    chirp_rate,
`endif
  input  logic [CH_NUM-1:0]            doinit,
  input  logic                         intr_pulse,
  input  logic                         epoch_pulse,
  output logic [CH_NUM*PHASE_W-1:0]    phase_rate_int,
  output logic [CH_NUM*PHASE_W-1:0]    phase_int,
  output logic [CH_NUM*CYCLES_W-1:0]   phase_cycles_int,
  output logic [CH_NUM*ADDR_W-1:0]     phase_addr,
  output logic                         int_valid
);

  logic int_valid_reg;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    phase_synth_channel #(
      .PHASE_W  (PHASE_W),
      .CYCLES_W (CYCLES_W),
      .ADDR_W   (ADDR_W)
    ) u_channel (
      .clk         (clk),
      .reset_n     (reset_n),
      .rate_in     (phase_rate[slice_lo(gi, PHASE_W) +: PHASE_W]),
      .offset_in   (phase_offset[slice_lo(gi, PHASE_W) +: PHASE_W]),
`ifdef PHASE_SYNTH_CHIRP_EN
      .chirp_in    (chirp_rate[slice_lo(gi, PHASE_W) +: PHASE_W]),
`endif
      .load        (doinit[gi] & intr_pulse),
      .epoch_pulse (epoch_pulse),
      .intr_pulse  (intr_pulse),
      .rate        (phase_rate_int[slice_lo(gi, PHASE_W) +: PHASE_W]),
      .phase_snap  (phase_int[slice_lo(gi, PHASE_W) +: PHASE_W]),
      .cycles_snap (phase_cycles_int[slice_lo(gi, CYCLES_W) +: CYCLES_W]),
      .addr        (phase_addr[slice_lo(gi, ADDR_W) +: ADDR_W])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_valid_reg <= 1'b0;
    end else begin
      int_valid_reg <= intr_pulse;
    end
  end

  assign int_valid = int_valid_reg;

endmodule
